// File: rtl/mix_sig_gen_pkg.sv
// Shared types and constants for the two-tone DDS sample source.
// The quarter-wave table holds round(1023*sin(2*pi*(k+0.5)/256)), k=0..63.
package mix_sig_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Mid-scale offset that turns the signed tone sum into offset binary.
  localparam int OFFSET = 2048;

  // Dither LFSR: x^16+x^14+x^13+x^11+1, taps on bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [9:0] SINE_ROM [64] = '{
    10'd13,   10'd38,   10'd63,   10'd88,   10'd113,  10'd138,  10'd163,  10'd187,
    10'd212,  10'd236,  10'd261,  10'd285,  10'd309,  10'd333,  10'd356,  10'd380,
    10'd403,  10'd426,  10'd449,  10'd471,  10'd493,  10'd515,  10'd537,  10'd558,
    10'd579,  10'd599,  10'd619,  10'd639,  10'd659,  10'd678,  10'd696,  10'd714,
    10'd732,  10'd750,  10'd766,  10'd783,  10'd799,  10'd814,  10'd829,  10'd844,
    10'd858,  10'd871,  10'd884,  10'd896,  10'd908,  10'd919,  10'd930,  10'd940,
    10'd950,  10'd959,  10'd967,  10'd975,  10'd983,  10'd989,  10'd995,  10'd1001,
    10'd1006, 10'd1010, 10'd1014, 10'd1017, 10'd1019, 10'd1021, 10'd1022, 10'd1023
  };

endpackage

// File: rtl/mix_sig_gen_sine_lut.sv
// Quarter-wave sine lookup: registered ROM read on a mirrored address,
// then a registered sign fold producing a signed 11-bit sample.
module mix_sig_gen_sine_lut (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         i_idx,
  output logic signed [10:0] o_tone
);
  import mix_sig_gen_pkg::*;

  logic [5:0]         w_addr;
  logic [9:0]         r_mag;
  logic               r_neg;
  logic signed [10:0] r_tone;

  // Quadrants 1 and 3 walk the quarter table backwards.
  assign w_addr = i_idx[6] ? (6'd63 - i_idx[5:0]) : i_idx[5:0];

  // Block-ROM style registered read; the sign travels alongside.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mag <= '0;
      r_neg <= 1'b0;
    end else begin
      r_mag <= SINE_ROM[w_addr];
      r_neg <= i_idx[7];
    end
  end

  // Apply the lower-half-period sign to the magnitude.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tone <= '0;
    end else begin
      r_tone <= r_neg ? -$signed({1'b0, r_mag}) : $signed({1'b0, r_mag});
    end
  end

  assign o_tone = r_tone;

endmodule

// File: rtl/mix_sig_gen.sv
// Two-tone DDS stimulus source: two phase accumulators, per-tone sine
// lookups, offset-binary sum, programmable sample rate.
// Optional dither build: define MIX_SIG_GEN_DITHER_EN.
module mix_sig_gen #(
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] ftw_a,
  input  logic [PHASE_W-1:0] ftw_b,
  input  logic [DIV_W-1:0]   div,
  output logic               busy,
  output logic               en,
  output logic [11:0]        xin
);
  import mix_sig_gen_pkg::*;

  state_t               r_state, w_state_next;
  logic                 w_load, w_tick;
  logic [PHASE_W-1:0]   r_ftw_a, r_ftw_b, r_acc_a, r_acc_b;
  logic [DIV_W-1:0]     r_div, r_cnt;
  logic [7:0]           r_idx_a, r_idx_b;
  // [0] phase index, [1] ROM read, [2] signed tone, [3] output sample
  logic [3:0]           r_vld;
  logic signed [10:0]   w_tone_a, w_tone_b;
  logic [11:0]          w_sum, w_xin_next, r_xin;

  // Next-state logic; the drain ends once nothing is left ahead of the
  // output stage, so busy drops on the edge the final strobe clears.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (stop) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (r_vld[2:0] == 3'b000) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_tick = (r_state == RUN) && (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Configuration latch, phase accumulators and sample-rate divider.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ftw_a <= '0;
      r_ftw_b <= '0;
      r_div   <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_ftw_a <= ftw_a;
      r_ftw_b <= ftw_b;
      r_div   <= div;
      r_acc_a <= '0;
      r_acc_b <= '0;
      r_cnt   <= '0;
    end else if (w_tick) begin
      r_acc_a <= r_acc_a + r_ftw_a;
      r_acc_b <= r_acc_b + r_ftw_b;
      r_cnt   <= r_div;
    end else if (r_state == RUN) begin
      r_cnt   <= r_cnt - DIV_W'(1);
    end
  end

  // Stage 1: capture the pre-increment phase index of each tone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx_a <= '0;
      r_idx_b <= '0;
    end else if (w_tick) begin
      r_idx_a <= r_acc_a[PHASE_W-1 -: 8];
      r_idx_b <= r_acc_b[PHASE_W-1 -: 8];
    end
  end

  // Pipeline valid shift register, fed by the divider tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_vld <= '0;
    else       r_vld <= {r_vld[2:0], w_tick};
  end

  mix_sig_gen_sine_lut u_lut_a (
    .clk    (clk),
    .rstn   (rstn),
    .i_idx  (r_idx_a),
    .o_tone (w_tone_a)
  );

  mix_sig_gen_sine_lut u_lut_b (
    .clk    (clk),
    .rstn   (rstn),
    .i_idx  (r_idx_b),
    .o_tone (w_tone_b)
  );

  // True sum lies in [2,4094], so 12-bit modular arithmetic is exact.
  assign w_sum = 12'(OFFSET) + {w_tone_a[10], w_tone_a} + {w_tone_b[10], w_tone_b};

`ifdef MIX_SIG_GEN_DITHER_EN
  logic [15:0] r_lfsr;

  // Dither LFSR, reseeded on start and stepped with every output sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_lfsr <= LFSR_SEED;
    else if (w_load)   r_lfsr <= LFSR_SEED;
    else if (r_vld[2]) r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  // +/-1 dither with the result held inside [1,4095].
  always_comb begin
    w_xin_next = w_sum;
    if (r_lfsr[0]) w_xin_next = (w_sum == 12'hFFF) ? 12'hFFF : w_sum + 12'd1;
    else           w_xin_next = (w_sum <= 12'd1)   ? 12'd1   : w_sum - 12'd1;
  end
`else
  assign w_xin_next = w_sum;
`endif

  // Stage 3: output sample register; holds between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_xin <= '0;
    else if (r_vld[2]) r_xin <= w_xin_next;
  end

  assign en   = r_vld[3];
  assign xin  = r_xin;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_mix_sig_gen.sv
// Directed bench for mix_sig_gen: latency, tone sequences, rate divider,
// drain/stop behaviour, config isolation and asynchronous reset.
module tb_mix_sig_gen;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [23:0] ftw_a = '0;
  logic [23:0] ftw_b = '0;
  logic [7:0]  div   = '0;
  logic        busy, en;
  logic [11:0] xin;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected sequence for ftw_a = 2^22, ftw_b = 0 (quarter-period steps).
  int seq4 [4] = '{2074, 3084, 2048, 1038};

  always #5 clk = ~clk;

  mix_sig_gen #(.PHASE_W(24), .DIV_W(8)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .stop  (stop),
    .ftw_a (ftw_a),
    .ftw_b (ftw_b),
    .div   (div),
    .busy  (busy),
    .en    (en),
    .xin   (xin)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [23:0] fa, input logic [23:0] fb, input logic [7:0] d);
    ftw_a = fa;
    ftw_b = fb;
    div   = d;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (en !== 1'b1 && n < 40) begin
      next_cycle();
      n++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      next_cycle();
      k++;
    end
    check_val("drain_done", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_en;
    logic prev_en;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_en", en, 0);
    check_val("rst_xin", xin, 0);
    check_val("rst_busy", busy, 0);
    rstn = 1'b1;
    next_cycle();

    // stop in IDLE is ignored
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    check_val("idle_stop_busy", busy, 0);

    // Test 1: both tones at phase 0, one sample per cycle
    do_start(24'd0, 24'd0, 8'd0);
    check_val("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      check_val("t1_latency_en", en, 0);
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      $display("t1 sample %0d: en=%0d xin=%0d", i, en, xin);
      check_val("t1_en", en, 1);
      check_val("t1_xin", xin, 2074);
      next_cycle();
    end

    // Stop during RUN; a start issued in DRAIN must be ignored
    stop = 1'b1;
    next_cycle();
    stop    = 1'b0;
    start   = 1'b1;
    ftw_a   = 24'h400000;
    n_en    = 0;
    prev_en = en;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      start = 1'b0;
      if (en === 1'b1) begin
        n_en++;
        check_val("drain_busy_high", busy, 1);
      end else if (prev_en === 1'b1) begin
        check_val("drain_busy_fall", busy, 0);
      end
      prev_en = en;
    end
    $display("drain: %0d strobes after stop", n_en);
    check_val("drain_en_count", n_en, 3);
    check_val("drain_start_ignored", busy, 0);
    check_val("drain_en_low", en, 0);
    check_val("hold_xin", xin, 2074);

    // Test 2: tone A at a quarter period per sample, div=0
    do_start(24'h400000, 24'd0, 8'd0);
    wait_en(n);
    check_val("t2_latency", n, 4);
    for (int i = 0; i < 8; i++) begin
      $display("t2 sample %0d: en=%0d xin=%0d", i, en, xin);
      check_val("t2_en", en, 1);
      check_val("t2_xin", xin, seq4[i % 4]);
      next_cycle();
    end
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    wait_idle();

    // Test 3: div=4, config inputs changed after start must not matter
    do_start(24'h400000, 24'd0, 8'd4);
    ftw_a = 24'd0;
    div   = 8'd0;
    wait_en(n);
    check_val("t3_latency", n, 4);
    for (int p = 0; p < 6; p++) begin
      $display("t3 pulse %0d: xin=%0d", p, xin);
      check_val("t3_xin", xin, seq4[p % 4]);
      next_cycle();
      check_val("t3_strobe_width", en, 0);
      wait_en(n);
      check_val("t3_gap", n + 1, 5);
    end

    // Asynchronous reset mid-run
    rstn = 1'b0;
    #1;
    check_val("arst_en", en, 0);
    check_val("arst_xin", xin, 0);
    check_val("arst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    do_start(24'd0, 24'd0, 8'd0);
    wait_en(n);
    $display("restart: first strobe after %0d cycles, xin=%0d", n, xin);
    check_val("restart_latency", n, 4);
    check_val("restart_xin", xin, 2074);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
